// File: rtl/ex_dmem_req.sv
// EX-stage data-memory request unit: SRAM-like req/addr_ok handshake, byte-lane alignment,
// and filtering of responses orphaned by flush. Define DMEM_ALE_CHECK_EN to enable misaligned-address detection.
module ex_dmem_req #(
    parameter int DISCARD_CNT_W = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_valid,
    input  logic        ex_mem_en,
    input  logic        ex_mem_we,
    input  logic [1:0]  ex_size,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_rkd_value,
    input  logic        ex_excep_in,
    input  logic        mem_allowin,
    input  logic        mem_waiting,
    input  logic        flush,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [31:0] data_sram_addr,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    output logic        mem_data_ok,
    output logic        ex_ready_go,
    output logic        ex_sram_requed,
    output logic        ex_excep_ale
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_CANCEL} state_t;

    localparam logic [DISCARD_CNT_W-1:0] CNT_MAX = '1;

    state_t                   state_reg, state_next;
    logic [DISCARD_CNT_W-1:0] discard_cnt_reg, discard_cnt_next;

    logic        wr_reg;
    logic [1:0]  size_reg;
    logic [31:0] addr_reg;
    logic [3:0]  wstrb_reg;
    logic [31:0] wdata_reg;

    logic        ale;
    logic        mem_op;
    logic        need_req;
    logic        cnt_full;
    logic        req;
    logic        accept;
    logic        ready_go;
    logic        requed;
    logic        move;
    logic        use_latched;
    logic        filt_data_ok;
    logic        orphan_inc;
    logic        wait_inc;
    logic        cnt_dec;
    logic [DISCARD_CNT_W:0] cnt_sum;
    logic [3:0]  wstrb_calc;
    logic [31:0] wdata_calc;

`ifdef DMEM_ALE_CHECK_EN
    assign ale = ex_valid & ex_mem_en & ~ex_excep_in &
                 (((ex_size == 2'd1) & ex_addr[0]) |
                  ((ex_size == 2'd2) & (ex_addr[1:0] != 2'b00)));
`else
    assign ale = 1'b0;
`endif

    assign mem_op   = ex_mem_en & ~ex_excep_in & ~ale;
    assign need_req = ex_valid & mem_op;
    assign cnt_full = (discard_cnt_reg == CNT_MAX);

    // Per-lane strobe and data replication; size 3 is treated like a word.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        localparam logic       HI   = (gi >= 2);
        assign wdata_calc[gi*8 +: 8] =
            (ex_size == 2'd0) ? ex_rkd_value[7:0] :
            (ex_size == 2'd1) ? ex_rkd_value[(gi % 2)*8 +: 8] :
                                ex_rkd_value[gi*8 +: 8];
        assign wstrb_calc[gi] = ex_mem_we &
            ((ex_size == 2'd0) ? (ex_addr[1:0] == LANE) :
             (ex_size == 2'd1) ? (ex_addr[1] == HI) : 1'b1);
    end

    // Once a request is raised its fields come from the capture registers, so a
    // cancelled request stays stable even after EX has moved on.
    assign use_latched = (state_reg == S_REQ) || (state_reg == S_CANCEL);

    assign req = ((state_reg == S_IDLE) & need_req & mem_allowin & ~cnt_full & ~flush) |
                 (state_reg == S_REQ) | (state_reg == S_CANCEL);
    assign accept   = req & data_sram_addr_ok;
    assign ready_go = ~mem_op | (state_reg == S_DONE) | (accept & (state_reg != S_CANCEL));
    assign requed   = (state_reg == S_DONE) |
                      (accept & ((state_reg == S_IDLE) | (state_reg == S_REQ)));
    assign move     = ready_go & mem_allowin;

    assign filt_data_ok = data_sram_data_ok & (discard_cnt_reg == '0);

    // DONE only persists while MEM is stalled: if the instruction advances in the
    // accept cycle, the unit is already free for the next one.
    always_comb begin
        state_next = state_reg;
        orphan_inc = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (req) begin
                    if (data_sram_addr_ok) state_next = move ? S_IDLE : S_DONE;
                    else                   state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (flush) begin
                    if (data_sram_addr_ok) begin
                        orphan_inc = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_CANCEL;
                    end
                end else if (data_sram_addr_ok) begin
                    state_next = move ? S_IDLE : S_DONE;
                end
            end
            S_DONE: begin
                if (flush) begin
                    orphan_inc = 1'b1;
                    state_next = S_IDLE;
                end else if (move) begin
                    state_next = S_IDLE;
                end
            end
            S_CANCEL: begin
                if (data_sram_addr_ok) begin
                    orphan_inc = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Net counter update, clamped at the maximum instead of wrapping.
    assign wait_inc = flush & mem_waiting & ~filt_data_ok;
    assign cnt_dec  = data_sram_data_ok & (discard_cnt_reg != '0);

    always_comb begin
        cnt_sum = {1'b0, discard_cnt_reg}
                + (DISCARD_CNT_W+1)'(orphan_inc)
                + (DISCARD_CNT_W+1)'(wait_inc)
                - (DISCARD_CNT_W+1)'(cnt_dec);
        discard_cnt_next = discard_cnt_reg;
        if (cnt_sum > {1'b0, CNT_MAX}) discard_cnt_next = CNT_MAX;
        else                           discard_cnt_next = cnt_sum[DISCARD_CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg       <= S_IDLE;
            discard_cnt_reg <= '0;
            wr_reg          <= 1'b0;
            size_reg        <= 2'd0;
            addr_reg        <= 32'd0;
            wstrb_reg       <= 4'd0;
            wdata_reg       <= 32'd0;
        end else begin
            state_reg       <= state_next;
            discard_cnt_reg <= discard_cnt_next;
            if ((state_reg == S_IDLE) && req) begin
                wr_reg    <= ex_mem_we;
                size_reg  <= ex_size;
                addr_reg  <= ex_addr;
                wstrb_reg <= wstrb_calc;
                wdata_reg <= wdata_calc;
            end
        end
    end

    // Outputs are forced low while reset is held.
    assign data_sram_req   = resetn & req;
    assign data_sram_wr    = resetn & (use_latched ? wr_reg : ex_mem_we);
    assign data_sram_size  = !resetn ? 2'd0  : (use_latched ? size_reg  : ex_size);
    assign data_sram_addr  = !resetn ? 32'd0 : (use_latched ? addr_reg  : ex_addr);
    assign data_sram_wstrb = !resetn ? 4'd0  : (use_latched ? wstrb_reg : wstrb_calc);
    assign data_sram_wdata = !resetn ? 32'd0 : (use_latched ? wdata_reg : wdata_calc);
    assign mem_data_ok     = resetn & filt_data_ok;
    assign ex_ready_go     = resetn & ready_go;
    assign ex_sram_requed  = resetn & requed;
    assign ex_excep_ale    = resetn & ale;

endmodule

// File: tb/tb_ex_dmem_req.sv
// Directed bench for ex_dmem_req: expected values are queued per cycle and popped at the sample point.
module tb_ex_dmem_req;
    logic        clk = 1'b0;
    logic        resetn;
    logic        ex_valid, ex_mem_en, ex_mem_we, ex_excep_in;
    logic [1:0]  ex_size;
    logic [31:0] ex_addr, ex_rkd_value;
    logic        mem_allowin, mem_waiting, flush;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic [3:0]  data_sram_wstrb;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic        mem_data_ok, ex_ready_go, ex_sram_requed, ex_excep_ale;

    ex_dmem_req #(.DISCARD_CNT_W(2)) dut (
        .clk(clk), .resetn(resetn),
        .ex_valid(ex_valid), .ex_mem_en(ex_mem_en), .ex_mem_we(ex_mem_we),
        .ex_size(ex_size), .ex_addr(ex_addr), .ex_rkd_value(ex_rkd_value),
        .ex_excep_in(ex_excep_in), .mem_allowin(mem_allowin),
        .mem_waiting(mem_waiting), .flush(flush),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .mem_data_ok(mem_data_ok), .ex_ready_go(ex_ready_go),
        .ex_sram_requed(ex_sram_requed), .ex_excep_ale(ex_excep_ale)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic expv(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_mis++;
            $error("FAIL scoreboard_empty: observed %h required an expectation", obs);
            return;
        end
        e = sb_q.pop_front();
        assert (obs === e.val) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
        end
    endtask

    task automatic exp_core(input string s, input logic rq, input logic rg,
                            input logic rd, input logic md);
        expv({s, ".req"},      32'(rq));
        expv({s, ".ready_go"}, 32'(rg));
        expv({s, ".requed"},   32'(rd));
        expv({s, ".mdata_ok"}, 32'(md));
    endtask

    task automatic cmp_core();
        check(32'(data_sram_req));
        check(32'(ex_ready_go));
        check(32'(ex_sram_requed));
        check(32'(mem_data_ok));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic en, input logic we,
                       input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        ex_valid = v; ex_mem_en = en; ex_mem_we = we;
        ex_size = sz; ex_addr = a; ex_rkd_value = d;
    endtask

    task automatic hs(input logic aok, input logic dok, input logic fl,
                      input logic mw, input logic ma);
        data_sram_addr_ok = aok; data_sram_data_ok = dok;
        flush = fl; mem_waiting = mw; mem_allowin = ma;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish required finish before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; ex_excep_in = 1'b0;
        drv(1'b0, 1'b0, 1'b1, 2'd2, 32'h0000_1234, 32'h0);
        hs(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(); tick();

        // reset: outputs low even with data_ok and store fields present
        exp_core("rst", 0, 0, 0, 0);
        expv("rst.addr", 32'h0); expv("rst.wstrb", 32'h0);
        @(negedge clk); cmp_core(); check(data_sram_addr); check(32'(data_sram_wstrb));
        tick();
        resetn = 1'b1;

        // store word, addr_ok same cycle
        drv(1'b1, 1'b1, 1'b1, 2'd2, 32'h0000_1000, 32'h1122_3344);
        hs(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_core("sw", 1, 1, 1, 0);
        expv("sw.addr", 32'h1000); expv("sw.wstrb", 32'hF);
        expv("sw.wdata", 32'h1122_3344); expv("sw.wr", 32'h1); expv("sw.size", 32'h2);
        @(negedge clk); cmp_core(); check(data_sram_addr); check(32'(data_sram_wstrb));
        check(data_sram_wdata); check(32'(data_sram_wr)); check(32'(data_sram_size));
        tick();
        drv(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0); hs(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_core("sw_after", 0, 1, 0, 0);
        @(negedge clk); cmp_core(); tick();

        // load byte, addr_ok delayed three cycles
        drv(1'b1, 1'b1, 1'b0, 2'd0, 32'h0000_1003, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            exp_core($sformatf("lb_wait%0d", i), 1, 0, 0, 0);
            expv($sformatf("lb_wait%0d.addr", i), 32'h1003);
            expv($sformatf("lb_wait%0d.wstrb", i), 32'h0);
            @(negedge clk); cmp_core(); check(data_sram_addr); check(32'(data_sram_wstrb));
            tick();
        end
        hs(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_core("lb_ok", 1, 1, 1, 0); expv("lb_ok.addr", 32'h1003);
        @(negedge clk); cmp_core(); check(data_sram_addr); tick();
        drv(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0); hs(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        exp_core("lb_data", 0, 1, 0, 1);
        @(negedge clk); cmp_core(); tick();

        // store half / byte lane alignment
        hs(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        drv(1'b1, 1'b1, 1'b1, 2'd1, 32'h0000_2002, 32'h1234_BEEF);
        expv("sh_hi.wstrb", 32'hC); expv("sh_hi.wdata", 32'hBEEF_BEEF);
        @(negedge clk); check(32'(data_sram_wstrb)); check(data_sram_wdata); tick();
        drv(1'b1, 1'b1, 1'b1, 2'd1, 32'h0000_2000, 32'h1234_BEEF);
        expv("sh_lo.wstrb", 32'h3);
        @(negedge clk); check(32'(data_sram_wstrb)); tick();
        drv(1'b1, 1'b1, 1'b1, 2'd0, 32'h0000_3001, 32'h1234_56A5);
        expv("sb.wstrb", 32'h2); expv("sb.wdata", 32'hA5A5_A5A5);
        @(negedge clk); check(32'(data_sram_wstrb)); check(data_sram_wdata); tick();

        // flush while request pending; request held, its response swallowed
        drv(1'b1, 1'b1, 1'b1, 2'd2, 32'h0000_4000, 32'hCAFE_F00D);
        hs(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_core("fr_issue", 1, 0, 0, 0);
        @(negedge clk); cmp_core(); tick();
        hs(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        exp_core("fr_flush", 1, 0, 0, 0);
        @(negedge clk); cmp_core(); tick();
        drv(1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_5000, 32'h0);
        hs(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_core("fr_cancel", 1, 0, 0, 0);
        expv("fr_cancel.addr", 32'h4000); expv("fr_cancel.wr", 32'h1);
        expv("fr_cancel.wdata", 32'hCAFE_F00D);
        @(negedge clk); cmp_core(); check(data_sram_addr); check(32'(data_sram_wr));
        check(data_sram_wdata); tick();
        hs(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_core("fr_cancel_ok", 1, 0, 0, 0); expv("fr_cancel_ok.addr", 32'h4000);
        @(negedge clk); cmp_core(); check(data_sram_addr); tick();
        hs(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        exp_core("fr_swallow", 1, 0, 0, 0); expv("fr_swallow.addr", 32'h5000);
        @(negedge clk); cmp_core(); check(data_sram_addr); tick();
        hs(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_core("fr_next_ok", 1, 1, 1, 0);
        @(negedge clk); cmp_core(); tick();
        drv(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0); hs(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        exp_core("fr_next_data", 0, 1, 0, 1);
        @(negedge clk); cmp_core(); tick();

        // flush in DONE with MEM waiting -> two responses swallowed
        drv(1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_6000, 32'h0);
        hs(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_core("fd_issue", 1, 0, 0, 0);
        @(negedge clk); cmp_core(); tick();
        hs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_core("fd_accept", 1, 1, 1, 0);
        @(negedge clk); cmp_core(); tick();
        hs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_core("fd_done", 0, 1, 1, 0);
        @(negedge clk); cmp_core(); tick();
        hs(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        exp_core("fd_flush", 0, 1, 1, 0);
        @(negedge clk); cmp_core(); tick();
        drv(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            hs(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            exp_core($sformatf("fd_resp%0d", i), 0, 1, 0, (i == 2));
            @(negedge clk); cmp_core(); tick();
        end

        // counter saturates at max and blocks new requests
        for (int i = 0; i < 4; i++) begin
            hs(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            exp_core($sformatf("sat_fill%0d", i), 0, 1, 0, 0);
            @(negedge clk); cmp_core(); tick();
        end
        drv(1'b1, 1'b1, 1'b0, 2'd0, 32'h0000_7002, 32'h0);
        hs(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_core("sat_block", 0, 0, 0, 0);
        @(negedge clk); cmp_core(); tick();
        hs(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        exp_core("sat_block_drain", 0, 0, 0, 0);
        @(negedge clk); cmp_core(); tick();
        hs(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_core("sat_issue", 1, 1, 1, 0);
        @(negedge clk); cmp_core(); tick();
        drv(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            hs(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            exp_core($sformatf("sat_resp%0d", i), 0, 1, 0, (i == 2));
            @(negedge clk); cmp_core(); tick();
        end

        // flush in IDLE suppresses the request
        drv(1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_8000, 32'h0);
        hs(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        exp_core("fi_flush", 0, 0, 0, 0);
        @(negedge clk); cmp_core(); tick();
        hs(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_core("fi_retry", 1, 1, 1, 0);
        @(negedge clk); cmp_core(); tick();

        // earlier exception: no request, EX free to advance
        ex_excep_in = 1'b1;
        drv(1'b1, 1'b1, 1'b1, 2'd2, 32'h0000_9000, 32'h0);
        exp_core("excep_in", 0, 1, 0, 0);
        @(negedge clk); cmp_core(); tick();
        ex_excep_in = 1'b0;

        // misaligned word load
        drv(1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_1002, 32'h0);
        hs(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef DMEM_ALE_CHECK_EN
        exp_core("ale_lw", 0, 1, 0, 0); expv("ale_lw.ale", 32'h1);
        @(negedge clk); cmp_core(); check(32'(ex_excep_ale)); tick();
        drv(1'b1, 1'b1, 1'b1, 2'd1, 32'h0000_2001, 32'h0);
        exp_core("ale_sh", 0, 1, 0, 0); expv("ale_sh.ale", 32'h1);
        @(negedge clk); cmp_core(); check(32'(ex_excep_ale)); tick();
`else
        exp_core("ale_lw", 1, 1, 1, 0); expv("ale_lw.ale", 32'h0);
        expv("ale_lw.addr", 32'h1002);
        @(negedge clk); cmp_core(); check(32'(ex_excep_ale)); check(data_sram_addr); tick();
        drv(1'b1, 1'b1, 1'b1, 2'd1, 32'h0000_2001, 32'h0);
        exp_core("ale_sh", 1, 1, 1, 0); expv("ale_sh.wstrb", 32'h3);
        @(negedge clk); cmp_core(); check(32'(data_sram_wstrb)); tick();
`endif
        drv(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        hs(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        n_cmp++;
        assert (sb_q.size() == 0) else begin
            n_mis++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
